// File: rtl/decade_onehot_decoder.sv
// decade_onehot_decoder
//   Watches the ten one-hot stage lines of a decade counter, turns the active
//   line back into a binary digit, checks that the counter only ever advances
//   one stage at a time, and counts completed decades (9 -> 0 wraps).
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset (priority over everything)
//   q_in[9:0]     one-hot stage lines, asynchronous to clk
//   clear_err     synchronous clear of the sticky error flags
//   digit[3:0]    current decoded stage 0..9
//   digit_valid   digit is locked to a legal stage
//   step          one-cycle pulse on each legal +1 advance
//   carry         one-cycle pulse on a 9 -> 0 advance (coincides with step)
//   decade_count  carries since reset, wraps modulo 2^CARRY_WIDTH
//   err_onehot    sticky: sample had zero or several bits set
//   err_seq       sticky: legal sample was neither the same nor the next stage
module decade_onehot_decoder #(
  parameter int CARRY_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [9:0]             q_in,
  input  logic                   clear_err,
  output logic [3:0]             digit,
  output logic                   digit_valid,
  output logic                   step,
  output logic                   carry,
  output logic [CARRY_WIDTH-1:0] decade_count,
  output logic                   err_onehot,
  output logic                   err_seq
);

  typedef enum logic {ACQUIRE, TRACK} state_t;

  state_t     state;
  logic [9:0] q_p0;
  logic [9:0] q_p1;
  logic       legal;
  logic [3:0] idx;
  logic [3:0] nxt;

  function automatic logic [3:0] ones_count(input logic [9:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 10; i++) r = r + {3'b000, v[i]};
    return r;
  endfunction

  function automatic logic [3:0] onehot_index(input logic [9:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 10; i++)
      if (v[i]) r = 4'(i);
    return r;
  endfunction

  // Stage p0/p1: two-flop synchroniser; contents are discarded on reset so a
  // pending advance cannot leak past a mid-operation reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_p0 <= 10'd0;
      q_p1 <= 10'd0;
    end else begin
      q_p0 <= q_in;
      q_p1 <= q_p0;
    end
  end

  always_comb begin
    legal = (ones_count(q_p1) == 4'd1);
    idx   = onehot_index(q_p1);
    nxt   = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
  end

  // Stage p2: tracker state and registered outputs.
  // Error sets are written after the clear, so a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ACQUIRE;
      digit        <= 4'd0;
      digit_valid  <= 1'b0;
      step         <= 1'b0;
      carry        <= 1'b0;
      decade_count <= '0;
      err_onehot   <= 1'b0;
      err_seq      <= 1'b0;
    end else begin
      step  <= 1'b0;
      carry <= 1'b0;
      if (clear_err) begin
        err_onehot <= 1'b0;
        err_seq    <= 1'b0;
      end
      case (state)
        ACQUIRE: begin
          // Power-up garbage is tolerated silently until a legal stage shows.
          if (legal) begin
            digit       <= idx;
            digit_valid <= 1'b1;
            state       <= TRACK;
          end
        end
        TRACK: begin
          if (!legal) begin
            err_onehot  <= 1'b1;
            digit_valid <= 1'b0;
            state       <= ACQUIRE;
          end else if (idx == digit) begin
            // holding on the current stage
          end else if (idx == nxt) begin
            digit <= idx;
            step  <= 1'b1;
            if (digit == 4'd9) begin
              carry        <= 1'b1;
              decade_count <= decade_count + CARRY_WIDTH'(1);
            end
          end else begin
            // Skip or backward move: flag it and resynchronise to the new stage.
            err_seq <= 1'b1;
            digit   <= idx;
          end
        end
        default: state <= ACQUIRE;
      endcase
    end
  end

endmodule

// File: tb/tb_decade_onehot_decoder.sv
module tb_decade_onehot_decoder;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [9:0]    q_in = 10'd0;
  logic          clear_err = 1'b0;
  logic [3:0]    digit;
  logic          digit_valid;
  logic          step;
  logic          carry;
  logic [CW-1:0] decade_count;
  logic          err_onehot;
  logic          err_seq;

  decade_onehot_decoder #(.CARRY_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .q_in(q_in), .clear_err(clear_err),
    .digit(digit), .digit_valid(digit_valid), .step(step), .carry(carry),
    .decade_count(decade_count), .err_onehot(err_onehot), .err_seq(err_seq)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int obs_steps = 0;
  int obs_carries = 0;

  // Reference model: the sample queue is two deep, the tracker is plain ints.
  logic [9:0] m_hist [$];
  int m_digit, m_count;
  bit m_valid, m_step, m_carry, m_eo, m_es;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [9:0] oh(input int n);
    logic [9:0] one;
    one = 10'd1;
    return one << n;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    m_hist.push_back(10'd0);
    m_hist.push_back(10'd0);
    m_digit = 0; m_count = 0;
    m_valid = 0; m_step = 0; m_carry = 0; m_eo = 0; m_es = 0;
  endtask

  task automatic model_edge(input logic r, input logic [9:0] q, input logic clr);
    logic [9:0] s;
    int ones, pos;
    bit new_eo, new_es;
    if (r) begin
      model_reset();
      return;
    end
    s = m_hist.pop_front();
    m_hist.push_back(q);
    ones = $countones(s);
    pos = 0;
    for (int i = 0; i < 10; i++) if (s[i]) pos = i;
    new_eo = 0; new_es = 0;
    m_step = 0; m_carry = 0;
    if (!m_valid) begin
      if (ones == 1) begin m_digit = pos; m_valid = 1; end
    end else if (ones != 1) begin
      new_eo = 1; m_valid = 0;
    end else if (pos == (m_digit + 1) % 10) begin
      m_step = 1;
      if (m_digit == 9) begin m_carry = 1; m_count = (m_count + 1) % (1 << CW); end
      m_digit = pos;
    end else if (pos != m_digit) begin
      new_es = 1; m_digit = pos;
    end
    m_eo = new_eo || (m_eo && !clr);
    m_es = new_es || (m_es && !clr);
  endtask

  task automatic tick(input logic r, input logic [9:0] q, input logic c);
    @(negedge clk);
    reset = r; q_in = q; clear_err = c;
    @(posedge clk);
    model_edge(r, q, c);
    #1;
    if (step) obs_steps++;
    if (carry) obs_carries++;
    check_val("digit", 32'(digit), 32'(m_digit));
    check_val("digit_valid", 32'(digit_valid), 32'(m_valid));
    check_val("step", 32'(step), 32'(m_step));
    check_val("carry", 32'(carry), 32'(m_carry));
    check_val("decade_count", 32'(decade_count), 32'(m_count));
    check_val("err_onehot", 32'(err_onehot), 32'(m_eo));
    check_val("err_seq", 32'(err_seq), 32'(m_es));
  endtask

  task automatic hold(input int stage, input int n);
    for (int i = 0; i < n; i++) tick(1'b0, oh(stage), 1'b0);
  endtask

  initial begin
    int cur, sel, n;
    logic [9:0] pat;
    model_reset();

    // Reset state, then lock onto stage 0 three edges after release.
    tick(1'b1, 10'd0, 1'b0);
    tick(1'b1, 10'd0, 1'b0);
    check_val("reset_valid", 32'(digit_valid), 32'd0);
    check_val("reset_count", 32'(decade_count), 32'd0);
    hold(0, 2);
    check_val("lock_early", 32'(digit_valid), 32'd0);
    hold(0, 1);
    check_val("lock_valid", 32'(digit_valid), 32'd1);
    check_val("lock_digit", 32'(digit), 32'd0);
    hold(0, 3);

    // One full decade walk, four cycles per stage.
    obs_steps = 0; obs_carries = 0;
    for (int s = 1; s <= 10; s++) hold(s % 10, 4);
    check_val("walk_steps", 32'(obs_steps), 32'd10);
    check_val("walk_carries", 32'(obs_carries), 32'd1);
    check_val("walk_count", 32'(decade_count), 32'd1);

    // 256 decades from a fresh reset: counter wraps back to 0.
    tick(1'b1, oh(0), 1'b0);
    hold(0, 4);
    obs_carries = 0;
    for (int d = 0; d < 256; d++)
      for (int s = 1; s <= 10; s++) hold(s % 10, 2);
    hold(0, 2);
    check_val("wrap_carries", 32'(obs_carries), 32'd256);
    check_val("wrap_count", 32'(decade_count), 32'd0);

    // Two-bit glitch at digit 3, then reacquire at stage 6.
    for (int s = 1; s <= 3; s++) hold(s, 3);
    tick(1'b0, 10'b0001100000, 1'b0);
    hold(3, 0);
    tick(1'b0, 10'b0001100000, 1'b0);
    tick(1'b0, 10'b0001100000, 1'b0);
    check_val("glitch_eo", 32'(err_onehot), 32'd1);
    check_val("glitch_digit", 32'(digit), 32'd3);
    hold(6, 4);
    check_val("reacq_digit", 32'(digit), 32'd6);
    check_val("reacq_es", 32'(err_seq), 32'd0);

    // Skip 4 -> 7, step to 8, then clear_err colliding with an 8 -> 0 jump.
    tick(1'b0, oh(6), 1'b1);
    for (int s = 7; s <= 14; s++) hold(s % 10, 3);
    hold(7, 3);
    check_val("skip_es", 32'(err_seq), 32'd1);
    hold(8, 3);
    tick(1'b0, oh(0), 1'b0);
    tick(1'b0, oh(0), 1'b0);
    tick(1'b0, oh(0), 1'b1);
    check_val("clr_collide", 32'(err_seq), 32'd1);
    tick(1'b0, oh(0), 1'b1);
    check_val("clr_alone", 32'(err_seq), 32'd0);

    // Reset lands on the edge where the synchronised sample shows 9 -> 0.
    for (int s = 1; s <= 9; s++) hold(s, 2);
    tick(1'b0, oh(0), 1'b0);
    tick(1'b0, oh(0), 1'b0);
    tick(1'b1, oh(0), 1'b0);
    check_val("rst9_carry", 32'(carry), 32'd0);
    check_val("rst9_count", 32'(decade_count), 32'd0);
    check_val("rst9_valid", 32'(digit_valid), 32'd0);

    // Randomised traffic: mostly legal advances with skips, glitches,
    // clears and the occasional reset mixed in.
    cur = 0;
    for (int k = 0; k < 700; k++) begin
      sel = $urandom_range(0, 99);
      n = $urandom_range(1, 4);
      if (sel < 80) begin
        cur = (cur + 1) % 10; pat = oh(cur);
      end else if (sel < 88) begin
        cur = $urandom_range(0, 9); pat = oh(cur);
      end else if (sel < 94) begin
        pat = ($urandom_range(0, 1) == 0) ? 10'd0 : (oh(cur) | oh($urandom_range(0, 9)));
        n = 1;
      end else begin
        pat = 10'($urandom);
        n = 1;
      end
      for (int i = 0; i < n; i++)
        tick(($urandom_range(0, 299) == 0), pat, ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decade_onehot_decoder.md
Name: decade_onehot_decoder

Overview:
Monitors the ten one-hot stage outputs of a decade counter (Q0..Q9) and turns them back into a binary digit.
It checks that exactly one line is high and that the counter only ever advances by one stage, and it counts completed decades (9→0 wraps).
It sits on the far side of a board or clock boundary from the counter, so its inputs are asynchronous and are synchronised first.
Intended uses are self-test of the counter and cascading decades into a binary total.

Parameters:
CARRY_WIDTH, 8, width of the completed-decade counter decade_count.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
q_in  input  10  one-hot stage lines; q_in[i] = stage Qi; asynchronous to clk.
clear_err  input  1  synchronous clear of the sticky error flags.
digit  output  4  current decoded stage, 0..9.
digit_valid  output  1  high while digit is locked to a legal stage.
step  output  1  one-cycle pulse on each legal +1 advance.
carry  output  1  one-cycle pulse on a 9→0 advance; coincides with step.
decade_count  output  CARRY_WIDTH  number of carries since reset; wraps modulo 2^CARRY_WIDTH.
err_onehot  output  1  sticky: a sample had zero bits or more than one bit set.
err_seq  output  1  sticky: a legal sample was neither the same stage nor the next stage.

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high. Reset has priority over all other inputs.
- Values while and after reset: digit=0, digit_valid=0, step=0, carry=0, decade_count=0, err_onehot=0, err_seq=0, both synchroniser stages=0, state=ACQUIRE.
- Synchroniser: two flop stages on all 10 bits. Call the second-stage output s. Decode s combinationally:
  - legal = exactly one bit set;
  - idx = position of that bit (0..9).
- Latency: q_in stable before rising edge k → s valid after edge k+1 → outputs updated at edge k+2.
- State ACQUIRE:
  - s legal → digit<=idx, digit_valid<=1, go to TRACK. No step, no carry.
  - s illegal → stay in ACQUIRE. No error flagged; all-zero or glitch data at power-up is tolerated.
- State TRACK, evaluated every cycle with nxt = (digit==9) ? 0 : digit+1. Cases in priority order:
  - s illegal → err_onehot<=1, digit_valid<=0, go to ACQUIRE. digit holds its last value.
  - idx==digit → no action.
  - idx==nxt → digit<=idx and step pulses for 1 cycle. If digit was 9, carry also pulses and decade_count<=decade_count+1, wrapping to 0.
  - any other legal idx (skip or backward move, including a restart to 0 from a digit other than 9) → err_seq<=1, digit<=idx to resynchronise, no step, no carry, remain in TRACK.
- Sticky errors and clear_err:
  - err_onehot and err_seq, once set, hold until reset or clear_err.
  - If clear_err and a new error of the same type occur in the same cycle, the flag remains 1 (set wins).
  - clear_err does not affect digit, digit_valid, decade_count or state.
- step and carry:
  - never asserted in ACQUIRE;
  - never asserted in the cycle that leaves ACQUIRE;
  - never asserted for 2 consecutive cycles unless s advanced in 2 consecutive cycles.
- Mid-operation reset: the next cycle is the full reset state, even if a step was pending in the pipeline. Synchroniser contents are discarded.
- Input rate: stage changes closer together than 1 clk period are not supported. Any resulting skip is reported as err_seq, never silently counted.

Test Plan:
- Reset, then hold q_in=10'b0000000001 → digit_valid=1 and digit=0 3 edges after reset deasserts; no step, no carry, no errors.
- Walk q_in one-hot 0→1→…→9→0 with 4 cycles per stage → 10 step pulses, exactly 1 carry coinciding with the 9→0 step, decade_count=1, digit=0, no errors.
- Run 256 complete decades with CARRY_WIDTH=8 → decade_count wraps to 0 on the 256th carry; carry still pulses on that cycle.
- While at digit 3, apply q_in=10'b0001100000 (two bits set) → err_onehot=1, digit_valid=0, digit holds 3. Then apply q_in=stage 6 → digit_valid=1, digit=6, err_seq stays 0, no step.
- While at digit 4, apply stage 7 → err_seq=1, digit=7, no step. Then stage 8 → step pulses. Then assert clear_err together with a stage 8→0 jump → err_seq remains 1; assert clear_err alone afterwards → err_seq=0.
- Assert reset for 1 cycle in the same cycle the synchronised sample shows 9→0 → no carry, decade_count=0, digit_valid=0, state ACQUIRE.
